// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 4-bit power-on initialiser.
// LCD_INIT_CLEAR_EN appends a Clear Display command to the sequence.
package lcd_pkg;

    localparam int unsigned DELAY_W = 20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PWR_WAIT,
        ST_NIB_SETUP,
        ST_NIB_PULSE,
        ST_NIB_HOLD,
        ST_NIB_WAIT,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        WAIT_4MS,
        WAIT_100US,
        WAIT_40US,
        WAIT_1US,
        WAIT_CLR
    } wait_sel_t;

    typedef struct packed {
        logic [3:0] nibble;
        logic       rs;
        wait_sel_t  wait_sel;
    } step_t;

    localparam logic [7:0] FUNC_SET   = 8'h28;
    localparam logic [7:0] ENTRY_MODE = 8'h06;
    localparam logic [7:0] DISP_ON    = 8'h0C;
    localparam logic [7:0] CLEAR      = 8'h01;

`ifdef LCD_INIT_CLEAR_EN
    localparam logic [3:0] LAST_STEP = 4'd11;
`else
    localparam logic [3:0] LAST_STEP = 4'd9;
`endif

endpackage

// File: rtl/lcd_delay_timer.sv
// Single shared down-counter: loaded with N-1, expired while it reads zero.
module lcd_delay_timer
    import lcd_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [DELAY_W-1:0] value,
    output logic               expired
);

    logic [DELAY_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - DELAY_W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/lcd_init_sequencer.sv
// Power-on initialisation FSM for an HD44780 LCD on a 4-bit port.
// Define LCD_INIT_CLEAR_EN to append Clear Display (steps 10/11).
module lcd_init_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWR   = 750000,
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_PULSE = 12,
    parameter int unsigned T_HOLD  = 1,
    parameter int unsigned T_4MS   = 205000,
    parameter int unsigned T_100US = 5000,
    parameter int unsigned T_40US  = 2000,
    parameter int unsigned T_1US   = 50,
    parameter int unsigned T_CLR   = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [3:0] lcd_data
);

    state_t             state;
    logic [3:0]         step;
    logic               load;
    logic [DELAY_W-1:0] load_value;
    logic               expired;
    step_t              cur_entry;
    step_t              next_entry;

    function automatic step_t step_rom(input logic [3:0] idx);
        case (idx)
            4'd0:    step_rom = '{nibble: 4'h3, rs: 1'b0, wait_sel: WAIT_4MS};
            4'd1:    step_rom = '{nibble: 4'h3, rs: 1'b0, wait_sel: WAIT_100US};
            4'd2:    step_rom = '{nibble: 4'h3, rs: 1'b0, wait_sel: WAIT_40US};
            4'd3:    step_rom = '{nibble: 4'h2, rs: 1'b0, wait_sel: WAIT_40US};
            4'd4:    step_rom = '{nibble: FUNC_SET[7:4],   rs: 1'b0, wait_sel: WAIT_1US};
            4'd5:    step_rom = '{nibble: FUNC_SET[3:0],   rs: 1'b0, wait_sel: WAIT_40US};
            4'd6:    step_rom = '{nibble: ENTRY_MODE[7:4], rs: 1'b0, wait_sel: WAIT_1US};
            4'd7:    step_rom = '{nibble: ENTRY_MODE[3:0], rs: 1'b0, wait_sel: WAIT_40US};
            4'd8:    step_rom = '{nibble: DISP_ON[7:4],    rs: 1'b0, wait_sel: WAIT_1US};
            4'd9:    step_rom = '{nibble: DISP_ON[3:0],    rs: 1'b0, wait_sel: WAIT_40US};
`ifdef LCD_INIT_CLEAR_EN
            4'd10:   step_rom = '{nibble: CLEAR[7:4],      rs: 1'b0, wait_sel: WAIT_1US};
            4'd11:   step_rom = '{nibble: CLEAR[3:0],      rs: 1'b0, wait_sel: WAIT_CLR};
`endif
            default: step_rom = '{nibble: 4'h0, rs: 1'b0, wait_sel: WAIT_1US};
        endcase
    endfunction

    function automatic logic [DELAY_W-1:0] cycles(input int unsigned n);
        cycles = DELAY_W'(n - 1);
    endfunction

    function automatic logic [DELAY_W-1:0] wait_cycles(input wait_sel_t sel);
        case (sel)
            WAIT_4MS:   wait_cycles = cycles(T_4MS);
            WAIT_100US: wait_cycles = cycles(T_100US);
            WAIT_40US:  wait_cycles = cycles(T_40US);
            WAIT_1US:   wait_cycles = cycles(T_1US);
            WAIT_CLR:   wait_cycles = cycles(T_CLR);
            default:    wait_cycles = cycles(T_1US);
        endcase
    endfunction

    assign cur_entry  = step_rom(step);
    assign next_entry = step_rom(step + 4'd1);
    assign lcd_rw     = 1'b0;

    // Timer is reloaded on the same edge the FSM changes state, so a state loaded with N lasts N cycles.
    always_comb begin
        load       = 1'b0;
        load_value = '0;
        case (state)
            ST_IDLE, ST_DONE: begin
                load       = start;
                load_value = cycles(T_PWR);
            end
            ST_PWR_WAIT: begin
                load       = expired;
                load_value = cycles(T_SETUP);
            end
            ST_NIB_SETUP: begin
                load       = expired;
                load_value = cycles(T_PULSE);
            end
            ST_NIB_PULSE: begin
                load       = expired;
                load_value = cycles(T_HOLD);
            end
            ST_NIB_HOLD: begin
                load       = expired;
                load_value = wait_cycles(cur_entry.wait_sel);
            end
            ST_NIB_WAIT: begin
                load       = expired && (step != LAST_STEP);
                load_value = cycles(T_SETUP);
            end
            default: begin
                load       = 1'b0;
                load_value = '0;
            end
        endcase
    end

    lcd_delay_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .value   (load_value),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            step     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state <= ST_PWR_WAIT;
                        step  <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                ST_PWR_WAIT: begin
                    if (expired) begin
                        state    <= ST_NIB_SETUP;
                        lcd_data <= cur_entry.nibble;
                        lcd_rs   <= cur_entry.rs;
                    end
                end
                ST_NIB_SETUP: begin
                    if (expired) begin
                        state <= ST_NIB_PULSE;
                        lcd_e <= 1'b1;
                    end
                end
                ST_NIB_PULSE: begin
                    if (expired) begin
                        state <= ST_NIB_HOLD;
                        lcd_e <= 1'b0;
                    end
                end
                ST_NIB_HOLD: begin
                    if (expired) begin
                        state <= ST_NIB_WAIT;
                    end
                end
                ST_NIB_WAIT: begin
                    if (expired) begin
                        if (step == LAST_STEP) begin
                            state <= ST_DONE;
                            step  <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state    <= ST_NIB_SETUP;
                            step     <= step + 4'd1;
                            lcd_data <= next_entry.nibble;
                            lcd_rs   <= next_entry.rs;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
